sar_frontend_model: RTL and testbench

- Synthesizable digital stand-in for the analog side of the successive-approximation loop: sample-and-hold, DAC settling and comparator.
- Tracks a digital input code while `sample` is high and holds it when `sample` falls.
- For each DAC code presented on `value`, waits a settling time, then returns `cmp` = (held < value). This is the polarity the SAR controller expects.
- Closes the loop around the controller on FPGA and in regression without real analog parts, and adds hold-capacitor droop so the controller's tolerance can be checked.

---
 rtl/sar_frontend_model_if.sv | 24 ++
 rtl/sar_frontend_model.sv | 155 +++++++++++++++
 tb/tb_sar_frontend_model.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_frontend_model_if.sv
// Bus between the SAR controller (master) and the analog front-end stand-in (slave).
interface sar_frontend_model_if #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
);
   logic [WIDTH-1:0] ain;
   logic             sample;
   logic [WIDTH-1:0] value;
   logic             cmp;
   logic             cmp_valid;
   logic [WIDTH-1:0] held;
   logic             hold_valid;
   logic [CW-1:0]    ncmp;

   modport master (
      output ain, sample, value,
      input  cmp, cmp_valid, held, hold_valid, ncmp
   );

   modport slave (
      input  ain, sample, value,
      output cmp, cmp_valid, held, hold_valid, ncmp
   );
endinterface

// File: rtl/sar_frontend_model.sv
// Digital model of sample-and-hold, DAC settling and comparator for closing the SAR loop
// without analog parts; includes optional hold-capacitor droop.
module sar_frontend_model #(
   parameter int WIDTH        = 16,
   parameter int SETTLE       = 1,
   parameter int DROOP_PERIOD = 0,
   parameter int CW           = 5
) (
   input  logic clk,
   input  logic reset,
   sar_frontend_model_if.slave bus
);

   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int DW = (DROOP_PERIOD > 1) ? $clog2(DROOP_PERIOD) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);
   localparam logic [DW-1:0] DROOP_LAST  = DW'((DROOP_PERIOD > 0) ? DROOP_PERIOD - 1 : 0);
   localparam bit            DROOP_ON    = (DROOP_PERIOD > 0);

   typedef enum logic {TRACK, HOLD} state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] held_q,    held_d;
   logic [WIDTH-1:0] value_q,   value_d;
   logic             cmp_q,     cmp_d;
   logic             cmp_valid_q, cmp_valid_d;
   logic             pending_q, pending_d;
   logic             armed_q,   armed_d;
   logic [SW-1:0]    settle_q,  settle_d;
   logic [DW-1:0]    droop_q,   droop_d;
   logic [CW-1:0]    ncmp_q,    ncmp_d;
   logic             hold_valid;
   logic             droop_step;
   logic             value_changed;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= TRACK;
      end else begin
         state_q <= state_d;
      end
   end

   // HOLD is only reachable once a code has actually been captured (armed).
   always_comb begin
      state_d = state_q;
      case (state_q)
         TRACK: if (!bus.sample && armed_q) state_d = HOLD;
         HOLD:  if (bus.sample)             state_d = TRACK;
         default: state_d = TRACK;
      endcase
   end

   always_comb begin
      hold_valid = (state_q == HOLD);
   end

   assign droop_step    = DROOP_ON && (state_q == HOLD) && (droop_q == DROOP_LAST);
   assign value_changed = (bus.value != value_q);

   always_comb begin
      held_d      = held_q;
      value_d     = value_q;
      cmp_d       = cmp_q;
      cmp_valid_d = cmp_valid_q;
      pending_d   = pending_q;
      armed_d     = armed_q;
      settle_d    = settle_q;
      droop_d     = droop_q;
      ncmp_d      = ncmp_q;

      case (state_q)
         TRACK: begin
            if (bus.sample) begin
               held_d  = bus.ain;
               armed_d = 1'b1;
            end else if (armed_q) begin
               pending_d = 1'b1;
               settle_d  = SETTLE_LOAD;
               ncmp_d    = '0;
               droop_d   = '0;
               value_d   = bus.value;
            end
         end
         HOLD: begin
            if (bus.sample) begin
               cmp_valid_d = 1'b0;
               pending_d   = 1'b0;
               held_d      = bus.ain;
               armed_d     = 1'b1;
            end else begin
               if (DROOP_ON) begin
                  droop_d = droop_step ? '0 : DW'(droop_q + 1'b1);
               end
               if (droop_step && (held_q != '0)) begin
                  held_d = held_q - 1'b1;
               end
               // A DAC change outranks a droop step; a droop step re-compares on the next edge.
               if (value_changed) begin
                  value_d     = bus.value;
                  pending_d   = 1'b1;
                  settle_d    = SETTLE_LOAD;
                  cmp_valid_d = 1'b0;
               end else if (droop_step) begin
                  pending_d   = 1'b1;
                  settle_d    = '0;
                  cmp_valid_d = 1'b0;
               end else if (pending_q) begin
                  if (settle_q != '0) begin
                     settle_d = settle_q - 1'b1;
                  end else begin
                     cmp_d       = (held_q < bus.value);
                     cmp_valid_d = 1'b1;
                     pending_d   = 1'b0;
                     if (ncmp_q != '1) ncmp_d = ncmp_q + 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         held_q      <= '0;
         value_q     <= '0;
         cmp_q       <= 1'b0;
         cmp_valid_q <= 1'b0;
         pending_q   <= 1'b0;
         armed_q     <= 1'b0;
         settle_q    <= '0;
         droop_q     <= '0;
         ncmp_q      <= '0;
      end else begin
         held_q      <= held_d;
         value_q     <= value_d;
         cmp_q       <= cmp_d;
         cmp_valid_q <= cmp_valid_d;
         pending_q   <= pending_d;
         armed_q     <= armed_d;
         settle_q    <= settle_d;
         droop_q     <= droop_d;
         ncmp_q      <= ncmp_d;
      end
   end

   assign bus.held       = held_q;
   assign bus.cmp        = cmp_q;
   assign bus.cmp_valid  = cmp_valid_q;
   assign bus.hold_valid = hold_valid;
   assign bus.ncmp       = ncmp_q;

endmodule

// File: tb/tb_sar_frontend_model.sv
// Bench for sar_frontend_model: three configurations driven in lockstep, checked against
// a timestamp-based reference model, a vector table and directed corner sequences.
module tb_sar_frontend_model;

   logic clk;
   logic reset;
   logic [15:0] drv_ain;
   logic        drv_sample;
   logic [15:0] drv_value;

   int tests;
   int fails;
   longint cyc;

   sar_frontend_model_if #(.WIDTH(16), .CW(5)) if_a ();
   sar_frontend_model_if #(.WIDTH(16), .CW(5)) if_b ();
   sar_frontend_model_if #(.WIDTH(16), .CW(5)) if_c ();

   assign if_a.ain = drv_ain;  assign if_a.sample = drv_sample;  assign if_a.value = drv_value;
   assign if_b.ain = drv_ain;  assign if_b.sample = drv_sample;  assign if_b.value = drv_value;
   assign if_c.ain = drv_ain;  assign if_c.sample = drv_sample;  assign if_c.value = drv_value;

   sar_frontend_model #(.WIDTH(16), .SETTLE(1), .DROOP_PERIOD(0), .CW(5)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a.slave));
   sar_frontend_model #(.WIDTH(16), .SETTLE(3), .DROOP_PERIOD(0), .CW(5)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b.slave));
   sar_frontend_model #(.WIDTH(16), .SETTLE(1), .DROOP_PERIOD(4), .CW(5)) dut_c (
      .clk(clk), .reset(reset), .bus(if_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: comparisons are scheduled as absolute cycle deadlines.
   typedef struct {
      int     settle;
      int     droop;
      bit     holding;
      bit     armed;
      bit     pending;
      bit     cmp;
      bit     cmp_valid;
      int     held;
      int     value_q;
      int     ncmp;
      longint due;
      longint next_droop;
   } model_t;

   model_t mdl[3];

   function automatic logic [31:0] pack(input logic [15:0] held, input logic hv,
                                        input logic cv, input logic cmp, input logic [4:0] ncmp);
      return {8'h00, ncmp, cmp, cv, hv, held};
   endfunction

   function automatic logic [31:0] dut_obs(input int i);
      case (i)
         0:       return pack(if_a.held, if_a.hold_valid, if_a.cmp_valid, if_a.cmp, if_a.ncmp);
         1:       return pack(if_b.held, if_b.hold_valid, if_b.cmp_valid, if_b.cmp, if_b.ncmp);
         default: return pack(if_c.held, if_c.hold_valid, if_c.cmp_valid, if_c.cmp, if_c.ncmp);
      endcase
   endfunction

   function automatic logic [31:0] model_obs(input int i);
      return pack(16'(mdl[i].held), mdl[i].holding, mdl[i].cmp_valid, mdl[i].cmp, 5'(mdl[i].ncmp));
   endfunction

   function automatic void model_edge(input int i);
      model_t m;
      bit droop_now;
      m = mdl[i];
      if (!reset) begin
         m.holding = 0; m.armed = 0; m.pending = 0; m.cmp = 0; m.cmp_valid = 0;
         m.held = 0; m.value_q = 0; m.ncmp = 0;
      end else if (!m.holding) begin
         if (drv_sample) begin
            m.held  = int'(drv_ain);
            m.armed = 1;
         end else if (m.armed) begin
            m.holding    = 1;
            m.ncmp       = 0;
            m.value_q    = int'(drv_value);
            m.pending    = 1;
            m.due        = cyc + m.settle + 1;
            m.next_droop = cyc + m.droop;
         end
      end else if (drv_sample) begin
         m.holding   = 0;
         m.cmp_valid = 0;
         m.pending   = 0;
         m.held      = int'(drv_ain);
         m.armed     = 1;
      end else begin
         droop_now = (m.droop > 0) && (cyc == m.next_droop);
         if (droop_now) begin
            m.next_droop = m.next_droop + m.droop;
            if (m.held > 0) m.held = m.held - 1;
         end
         if (int'(drv_value) != m.value_q) begin
            m.value_q   = int'(drv_value);
            m.pending   = 1;
            m.due       = cyc + m.settle + 1;
            m.cmp_valid = 0;
         end else if (droop_now) begin
            m.pending   = 1;
            m.due       = cyc + 1;
            m.cmp_valid = 0;
         end else if (m.pending && cyc >= m.due) begin
            m.cmp       = (m.held < int'(drv_value));
            m.cmp_valid = 1;
            m.pending   = 0;
            if (m.ncmp < 31) m.ncmp = m.ncmp + 1;
         end
      end
      mdl[i] = m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One clock: drive, step the model at the edge, compare all three DUTs half a cycle later.
   task automatic applyStimulus(input logic rst, input logic [15:0] a, input logic s, input logic [15:0] v);
      reset      = rst;
      drv_ain    = a;
      drv_sample = s;
      drv_value  = v;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) model_edge(i);
      @(negedge clk);
      checkOutput("model_a", dut_obs(0), model_obs(0));
      checkOutput("model_b", dut_obs(1), model_obs(1));
      checkOutput("model_c", dut_obs(2), model_obs(2));
   endtask

   typedef struct {
      logic        rst;
      logic [15:0] ain;
      logic        sample;
      logic [15:0] value;
      logic [15:0] held;
      logic        hv;
      logic        cv;
      logic        cmp;
      logic [4:0]  ncmp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [15:0] result;
      logic [15:0] trial;
      logic [15:0] hexp;
      logic [15:0] hprev;
      logic [15:0] v;
      bit got;
      bit held_ok;
      bit cv_exp;

      tests = 0;
      fails = 0;
      cyc   = 0;
      reset = 1'b0; drv_ain = '0; drv_sample = 1'b0; drv_value = '0;
      mdl[0].settle = 1; mdl[0].droop = 0;
      mdl[1].settle = 3; mdl[1].droop = 0;
      mdl[2].settle = 1; mdl[2].droop = 4;

      // Basic compare on the SETTLE=1 instance.
      for (int r = 0; r < 5; r++) tbl[r] = '{1'b0, 16'd11037, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0};
      for (int r = 5; r < 8; r++) tbl[r] = '{1'b1, 16'd11037, 1'b1, 16'd0, 16'd11037, 1'b0, 1'b0, 1'b0, 5'd0};
      tbl[8]  = '{1'b1, 16'd11037, 1'b0, 16'd32768, 16'd11037, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[9]  = '{1'b1, 16'd11037, 1'b0, 16'd32768, 16'd11037, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[10] = '{1'b1, 16'd11037, 1'b0, 16'd32768, 16'd11037, 1'b1, 1'b1, 1'b1, 5'd1};
      tbl[11] = '{1'b1, 16'd11037, 1'b0, 16'd32768, 16'd11037, 1'b1, 1'b1, 1'b1, 5'd1};
      for (int r = 0; r < 12; r++) begin
         applyStimulus(tbl[r].rst, tbl[r].ain, tbl[r].sample, tbl[r].value);
         checkOutput("table", dut_obs(0),
                     pack(tbl[r].held, tbl[r].hv, tbl[r].cv, tbl[r].cmp, tbl[r].ncmp));
      end

      // Full 16-bit successive-approximation search driven by a bench-side controller.
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 16'd11037, 1, 0);
      applyStimulus(1, 16'd11037, 1, 0);
      result  = '0;
      held_ok = 1;
      for (int b = 15; b >= 0; b--) begin
         trial = result | 16'(1 << b);
         applyStimulus(1, 16'd11037, 0, trial);
         got = 0;
         for (int n = 0; n < 20; n++) begin
            if (if_a.held != 16'd11037) held_ok = 0;
            if (if_a.cmp_valid) begin got = 1; break; end
            applyStimulus(1, 16'd11037, 0, trial);
         end
         checkOutput("search_wait", 32'(got), 32'd1);
         if (!if_a.cmp) result = trial;
      end
      checkOutput("search_result", 32'(result), 32'd11037);
      checkOutput("search_ncmp", 32'(if_a.ncmp), 32'd16);
      checkOutput("search_held", 32'(held_ok), 32'd1);

      // Equality and settle restart on the SETTLE=3 instance.
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 16'd11037, 1, 0);
      applyStimulus(1, 16'd11037, 0, 0);
      got = 0;
      for (int n = 0; n < 10; n++) begin
         if (if_b.cmp_valid) begin got = 1; break; end
         applyStimulus(1, 16'd11037, 0, 0);
      end
      checkOutput("eq_wait", 32'(got), 32'd1);
      for (int n = 0; n < 4; n++) begin
         applyStimulus(1, 16'd11037, 0, 16'd11037);
         checkOutput("eq_settling", 32'(if_b.cmp_valid), 32'd0);
      end
      applyStimulus(1, 16'd11037, 0, 16'd11037);
      checkOutput("eq_result", {30'd0, if_b.cmp_valid, if_b.cmp}, 32'b10);
      for (int n = 0; n < 6; n++) begin
         v = (n < 2) ? 16'd5000 : 16'd11038;
         applyStimulus(1, 16'd11037, 0, v);
         checkOutput("restart_settling", 32'(if_b.cmp_valid), 32'd0);
      end
      applyStimulus(1, 16'd11037, 0, 16'd11038);
      checkOutput("restart_result", {30'd0, if_b.cmp_valid, if_b.cmp}, 32'b11);

      // Droop on the DROOP_PERIOD=4 instance: held steps 2,1,0 and cmp refreshes after each step.
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 16'd2, 1, 16'd1);
      applyStimulus(1, 16'd2, 1, 16'd1);
      hprev = 16'd2;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 16'd2, 0, 16'd1);
         hexp   = (i >= 8) ? 16'd0 : 16'(2 - i / 4);
         cv_exp = (i >= 2) && (i % 4 != 0);
         checkOutput("droop", {14'd0, if_c.held, if_c.cmp_valid, if_c.cmp & if_c.cmp_valid},
                     {14'd0, hexp, cv_exp, cv_exp & (hprev < 16'd1)});
         hprev = hexp;
      end

      // Reset in the middle of settling, then sample low without a prior high.
      applyStimulus(1, 16'd2, 0, 16'd77);
      applyStimulus(0, 16'd2, 0, 16'd77);
      checkOutput("midreset_a", dut_obs(0), 32'd0);
      checkOutput("midreset_b", dut_obs(1), 32'd0);
      checkOutput("midreset_c", dut_obs(2), 32'd0);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 16'd999, 0, 16'd77);
         checkOutput("unarmed_track", dut_obs(0), 32'd0);
      end

      // Re-sample during HOLD.
      applyStimulus(1, 16'd11037, 1, 16'd40000);
      applyStimulus(1, 16'd11037, 0, 16'd40000);
      got = 0;
      for (int n = 0; n < 10; n++) begin
         if (if_a.cmp_valid) begin got = 1; break; end
         applyStimulus(1, 16'd11037, 0, 16'd40000);
      end
      checkOutput("resample_wait", 32'(got), 32'd1);
      checkOutput("resample_ncmp1", 32'(if_a.ncmp), 32'd1);
      applyStimulus(1, 16'd500, 1, 16'd40000);
      checkOutput("resample_drop", {14'd0, if_a.hold_valid, if_a.cmp_valid, if_a.held}, {14'd0, 2'b00, 16'd500});
      applyStimulus(1, 16'd500, 0, 16'd40000);
      checkOutput("resample_rehold", {10'd0, if_a.hold_valid, if_a.ncmp, if_a.held}, {10'd0, 1'b1, 5'd0, 16'd500});

      // Comparison counter saturation.
      for (int n = 0; n < 40; n++) begin
         v = 16'(100 + n);
         for (int k = 0; k < 3; k++) applyStimulus(1, 16'd500, 0, v);
      end
      checkOutput("ncmp_saturate", 32'(if_a.ncmp), 32'd31);

      // Randomized traffic, checked only against the reference model.
      applyStimulus(0, 0, 0, 0);
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 7) == 0) drv_sample = ~drv_sample;
         if ($urandom_range(0, 3) == 0) drv_value = 16'($urandom);
         applyStimulus(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, 16'($urandom), drv_sample, drv_value);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
